ps2_temp_band_classifier: RTL and testbench
===========================================

// Module: ps2_temp_band_classifier
// PURPOSE
//  Parametrised successor to the two-digit scan-code temperature decoder.
//  - Consumes a byte stream of PS/2 set-2 scan codes, one byte per key_valid pulse.
//  - Accumulates up to NDIGITS decimal digits; Enter commits the value.
//  - Classifies the committed value into NBANDS one-hot bands using parameter bounds.
//  - Sits between the PS/2 receiver and the fan/actuator control logic.
// PARAMETERS
//  NDIGITS  2                             max decimal digits per entry
//  VAL_W    7                             value width; must hold 10^NDIGITS-1
//  NBANDS   4                             number of bands = width of band output
//  BOUNDS   {7'd99,7'd47,7'd36,7'd24}     packed NBANDS*VAL_W inclusive upper bounds;
//                                         slice i = bound of band i, strictly ascending
// PORTS
//  CLK        in   1              clock, rising edge
//  reset      in   1              asynchronous, active-high
//  key_valid  in   1              one-cycle strobe, key_code valid
//  key_code   in   8              PS/2 set-2 scan code byte
//  value      out  VAL_W          last committed value, binary
//  band       out  NBANDS         one-hot band of value; all-zero if out of range
//  range_err  out  1              committed value > top bound
//  commit     out  1              one-cycle pulse: value/band just updated
//  entry_err  out  1              one-cycle pulse: Enter rejected (bad entry)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, accumulator/digit count/flags cleared.
//    Reset mid-entry discards the partial entry.
//  - Bytes are processed only on key_valid=1; other cycles hold state.
//  - Break: byte 0xF0 sets brk. The next byte is discarded and clears brk.
//    Key releases never enter digits.
//  - Extended: byte 0xE0 is ignored, with no state change.
//  - Digit codes 0x45,16,1E,26,25,2E,36,3D,3E,46 map to 0..9.
//  - FSM states:
//    IDLE:  digit -> acc=d, cnt=1, go ENTRY.
//           Enter (0x5A) -> no action.
//           Backspace (0x66) / Esc (0x76) -> no action.
//    ENTRY: digit with cnt<NDIGITS -> acc=acc*10+d, cnt++.
//           digit with cnt==NDIGITS -> go ERROR.
//           Enter -> commit, go IDLE.
//           Backspace/Esc -> clear acc/cnt, go IDLE.
//    ERROR: digit ignored.
//           Enter -> entry_err pulse, clear, go IDLE.
//           Backspace/Esc -> clear, go IDLE.
//  - Any other code is ignored in every state.
//  - Commit: on the cycle after the Enter byte:
//    - value=acc, band/range_err computed from acc, commit=1 for 1 cycle.
//    - Latency is 1 clock from the key_valid of Enter.
//  - Band rule:
//    - band[0]=1 iff acc<=BOUNDS[0].
//    - band[i]=1 iff BOUNDS[i-1]<acc<=BOUNDS[i].
//    - acc>BOUNDS[NBANDS-1] -> band=0, range_err=1; otherwise range_err=0.
//  - Outputs value/band/range_err hold between commits.
//    A rejected Enter leaves them unchanged.
//  - acc*10+d is computed at VAL_W+4 bits. cnt bounds it, so no wrap occurs.
//  - brk has priority: 0xF0 followed by 0x5A discards the 0x5A and does not commit.
// CONFIGURATION
//  - KEYPAD_EN defined:
//    - Numpad digits are also accepted: 70,69,72,7A,6B,73,74,6C,75,7D -> 0..9.
//    - E0 5A (keypad Enter) commits, since E0 is ignored.
//  - KEYPAD_EN undefined:
//    - Numpad codes are ignored as unknown.
//    - Keypad Enter still works through the E0 skip.
// TESTING
//  - 1E,2E,5A (2,5,Enter) -> 1 clk after 5A: value=25, band=4'b0010, commit pulse.
//  - 46,46,5A (99) -> band=4'b1000, range_err=0.
//    With BOUNDS top=47: band=0, range_err=1.
//  - 16,F0,16,26,F0,26,5A -> value=13; break bytes produce no digits.
//  - 16,1E,26,5A (3 digits, NDIGITS=2) -> entry_err pulse.
//    value/band keep prior values; no commit.
//  - 26,66,2E,5A -> value=5, band=4'b0001.
//    Enter from IDLE -> no commit.
//  - Reset asserted after 16 then released, then 1E,5A -> value=2.
//    With KEYPAD_EN: 69,72,E0,5A -> value=12.

Source files
------------

// File: rtl/ps2_temp_band_classifier_if.sv
// Scan-code input and classified-temperature output bundle for ps2_temp_band_classifier.
interface ps2_temp_band_classifier_if #(
  parameter int unsigned VAL_W  = 7,
  parameter int unsigned NBANDS = 4
);
  logic              key_valid;
  logic [7:0]        key_code;
  logic [VAL_W-1:0]  value;
  logic [NBANDS-1:0] band;
  logic              range_err;
  logic              commit;
  logic              entry_err;

  modport master (
    output key_valid, key_code,
    input  value, band, range_err, commit, entry_err
  );

  modport slave (
    input  key_valid, key_code,
    output value, band, range_err, commit, entry_err
  );
endinterface

// File: rtl/ps2_temp_band_classifier.sv
// PS/2 set-2 decimal entry accumulator with one-hot band classification of the committed value.
// Define KEYPAD_EN to also accept numpad digit codes.
module ps2_temp_band_classifier #(
  parameter int unsigned NDIGITS = 2,
  parameter int unsigned VAL_W   = 7,
  parameter int unsigned NBANDS  = 4,
  parameter logic [NBANDS*VAL_W-1:0] BOUNDS = {7'd99, 7'd47, 7'd36, 7'd24}
) (
  input  logic CLK,
  input  logic reset,
  ps2_temp_band_classifier_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(NDIGITS + 1);
  localparam int unsigned WIDE_W = VAL_W + 4;

  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_BKSP  = 8'h66;
  localparam logic [7:0] CODE_ESC   = 8'h76;

  typedef enum logic [1:0] {IDLE, ENTRY, ERROR} state_t;

  state_t            state, state_nxt;
  logic [VAL_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              brk, brk_nxt;
  logic              do_commit, do_reject;

  logic [VAL_W-1:0]  value_q;
  logic [NBANDS-1:0] band_q;
  logic              range_err_q, commit_q, entry_err_q;

  logic [NBANDS-1:0] band_c;
  logic              range_err_c;
  logic [4:0]        dec_c;
  logic              is_digit_c, is_enter_c, is_cancel_c;
  logic [3:0]        digit_c;

  // {valid, digit} for a scan code
  function automatic logic [4:0] decode_digit(input logic [7:0] code);
    logic [4:0] r;
    r = '0;
    unique case (code)
      8'h45: r = {1'b1, 4'd0};
      8'h16: r = {1'b1, 4'd1};
      8'h1E: r = {1'b1, 4'd2};
      8'h26: r = {1'b1, 4'd3};
      8'h25: r = {1'b1, 4'd4};
      8'h2E: r = {1'b1, 4'd5};
      8'h36: r = {1'b1, 4'd6};
      8'h3D: r = {1'b1, 4'd7};
      8'h3E: r = {1'b1, 4'd8};
      8'h46: r = {1'b1, 4'd9};
`ifdef KEYPAD_EN
      8'h70: r = {1'b1, 4'd0};
      8'h69: r = {1'b1, 4'd1};
      8'h72: r = {1'b1, 4'd2};
      8'h7A: r = {1'b1, 4'd3};
      8'h6B: r = {1'b1, 4'd4};
      8'h73: r = {1'b1, 4'd5};
      8'h74: r = {1'b1, 4'd6};
      8'h6C: r = {1'b1, 4'd7};
      8'h75: r = {1'b1, 4'd8};
      8'h7D: r = {1'b1, 4'd9};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  assign dec_c       = decode_digit(bus.key_code);
  assign is_digit_c  = dec_c[4];
  assign digit_c     = dec_c[3:0];
  assign is_enter_c  = (bus.key_code == CODE_ENTER);
  assign is_cancel_c = (bus.key_code == CODE_BKSP) || (bus.key_code == CODE_ESC);

  // State and entry datapath register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      brk   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      brk   <= brk_nxt;
    end
  end

  // Next-state: break prefix swallows the following byte before any FSM action
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    brk_nxt   = brk;
    do_commit = 1'b0;
    do_reject = 1'b0;
    if (bus.key_valid) begin
      if (brk) begin
        brk_nxt = 1'b0;
      end else if (bus.key_code == CODE_BRK) begin
        brk_nxt = 1'b1;
      end else if (bus.key_code != CODE_EXT) begin
        unique case (state)
          IDLE: begin
            if (is_digit_c) begin
              acc_nxt   = VAL_W'(digit_c);
              cnt_nxt   = CNT_W'(1);
              state_nxt = ENTRY;
            end
          end
          ENTRY: begin
            if (is_digit_c) begin
              if (cnt < CNT_W'(NDIGITS)) begin
                acc_nxt = VAL_W'(WIDE_W'(acc) * WIDE_W'(10) + WIDE_W'(digit_c));
                cnt_nxt = cnt + CNT_W'(1);
              end else begin
                state_nxt = ERROR;
              end
            end else if (is_enter_c) begin
              do_commit = 1'b1;
              acc_nxt   = '0;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end else if (is_cancel_c) begin
              acc_nxt   = '0;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end
          end
          ERROR: begin
            if (is_enter_c || is_cancel_c) begin
              do_reject = is_enter_c;
              acc_nxt   = '0;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // Output decode: band of the current accumulator, captured on commit
  always_comb begin
    band_c      = '0;
    range_err_c = acc > BOUNDS[(NBANDS-1)*VAL_W +: VAL_W];
    band_c[0]   = acc <= BOUNDS[VAL_W-1:0];
    for (int i = 1; i < NBANDS; i++) begin
      band_c[i] = (acc <= BOUNDS[i*VAL_W +: VAL_W]) && (acc > BOUNDS[(i-1)*VAL_W +: VAL_W]);
    end
  end

  // Registered outputs; value/band/range_err hold between commits
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      value_q     <= '0;
      band_q      <= '0;
      range_err_q <= 1'b0;
      commit_q    <= 1'b0;
      entry_err_q <= 1'b0;
    end else begin
      commit_q    <= do_commit;
      entry_err_q <= do_reject;
      if (do_commit) begin
        value_q     <= acc;
        band_q      <= band_c;
        range_err_q <= range_err_c;
      end
    end
  end

  assign bus.value     = value_q;
  assign bus.band      = band_q;
  assign bus.range_err = range_err_q;
  assign bus.commit    = commit_q;
  assign bus.entry_err = entry_err_q;

endmodule

// File: tb/tb_ps2_temp_band_classifier.sv
// Scoreboard bench: default-bounds DUT (a) and a tight-bounds DUT (b) driven by the same scan codes.
module tb_ps2_temp_band_classifier;

  localparam int EV_NONE   = 0;
  localparam int EV_COMMIT = 1;
  localparam int EV_REJECT = 2;

  logic       CLK;
  logic       reset;
  logic       kv;
  logic [7:0] kc;
  int         cyc;
  int         n_checks;
  int         n_fail;
  int         n_pushed;
  int         n_events;

  typedef struct {
    int         cyc;
    bit         rej;
    int         val;
    logic [3:0] ba;
    bit         ra;
    logic [3:0] bb;
    bit         rb;
  } exp_t;

  exp_t q[$];
  exp_t e;

  ps2_temp_band_classifier_if #(.VAL_W(7), .NBANDS(4)) bus_a ();
  ps2_temp_band_classifier_if #(.VAL_W(7), .NBANDS(4)) bus_b ();

  assign bus_a.key_valid = kv;
  assign bus_a.key_code  = kc;
  assign bus_b.key_valid = kv;
  assign bus_b.key_code  = kc;

  ps2_temp_band_classifier #(
    .NDIGITS(2), .VAL_W(7), .NBANDS(4),
    .BOUNDS({7'd99, 7'd47, 7'd36, 7'd24})
  ) dut_a (
    .CLK(CLK), .reset(reset), .bus(bus_a)
  );

  ps2_temp_band_classifier #(
    .NDIGITS(2), .VAL_W(7), .NBANDS(4),
    .BOUNDS({7'd47, 7'd36, 7'd24, 7'd12})
  ) dut_b (
    .CLK(CLK), .reset(reset), .bus(bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: every commit/entry_err event must match the oldest expectation
  always @(negedge CLK) begin
    if (!reset && (bus_a.commit || bus_a.entry_err || bus_b.commit || bus_b.entry_err)) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: commit_a=%0b entry_err_a=%0b at cycle %0d, required no event",
                 bus_a.commit, bus_a.entry_err, cyc);
      end else begin
        e = q.pop_front();
        n_events++;
        check("latency",     cyc,             e.cyc);
        check("commit_a",    int'(bus_a.commit),    int'(!e.rej));
        check("entry_err_a", int'(bus_a.entry_err), int'(e.rej));
        check("commit_b",    int'(bus_b.commit),    int'(!e.rej));
        check("entry_err_b", int'(bus_b.entry_err), int'(e.rej));
        check("value_a",     int'(bus_a.value),     e.val);
        check("value_b",     int'(bus_b.value),     e.val);
        check("band_a",      int'(bus_a.band),      int'(e.ba));
        check("range_err_a", int'(bus_a.range_err), int'(e.ra));
        check("band_b",      int'(bus_b.band),      int'(e.bb));
        check("range_err_b", int'(bus_b.range_err), int'(e.rb));
      end
    end
  end

  // Send n scan codes; the expectation is queued with the last byte
  task automatic run(input logic [7:0] c [8], input int n, input int ev, input int val,
                     input logic [3:0] ba, input bit ra, input logic [3:0] bb, input bit rb);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      kv = 1'b1;
      kc = c[i];
      if (i == n - 1 && ev != EV_NONE) begin
        x.cyc = cyc + 1;
        x.rej = (ev == EV_REJECT);
        x.val = val;
        x.ba  = ba;
        x.ra  = ra;
        x.bb  = bb;
        x.rb  = rb;
        q.push_back(x);
        n_pushed++;
      end
      @(negedge CLK);
      kv = 1'b0;
      kc = 8'h00;
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_value_a"},     int'(bus_a.value),     0);
    check({tag, "_band_a"},      int'(bus_a.band),      0);
    check({tag, "_range_err_a"}, int'(bus_a.range_err), 0);
    check({tag, "_commit_a"},    int'(bus_a.commit),    0);
    check({tag, "_entry_err_a"}, int'(bus_a.entry_err), 0);
    check({tag, "_value_b"},     int'(bus_b.value),     0);
    check({tag, "_band_b"},      int'(bus_b.band),      0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_pushed = 0;
    n_events = 0;
    reset    = 1'b1;
    kv       = 1'b0;
    kc       = 8'h00;
    repeat (3) @(negedge CLK);
    check_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge CLK);

    // 25: a band1; b band2
    run('{8'h1E, 8'h2E, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, EV_COMMIT, 25, 4'b0010, 0, 4'b0100, 0);
    // 99: a top band; b out of range
    run('{8'h46, 8'h46, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, EV_COMMIT, 99, 4'b1000, 0, 4'b0000, 1);
    // 1, release 1, 3, release 3 -> 13
    run('{8'h16, 8'hF0, 8'h16, 8'h26, 8'hF0, 8'h26, 8'h5A, 8'h00}, 7, EV_COMMIT, 13, 4'b0001, 0, 4'b0010, 0);
    // Three digits: rejected, outputs hold 13
    run('{8'h16, 8'h1E, 8'h26, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}, 4, EV_REJECT, 13, 4'b0001, 0, 4'b0010, 0);
    // Backspace discards 3, then 5
    run('{8'h26, 8'h66, 8'h2E, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}, 4, EV_COMMIT, 5, 4'b0001, 0, 4'b0001, 0);
    // Enter from IDLE: nothing
    run('{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, EV_NONE, 0, 4'b0, 0, 4'b0, 0);
    // Released Enter must not commit; the real Enter commits 2
    run('{8'h1E, 8'hF0, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}, 4, EV_COMMIT, 2, 4'b0001, 0, 4'b0001, 0);
    // Band edges
    run('{8'h1E, 8'h25, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, EV_COMMIT, 24, 4'b0001, 0, 4'b0010, 0);
    run('{8'h25, 8'h3E, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, EV_COMMIT, 48, 4'b1000, 0, 4'b0000, 1);
    run('{8'h25, 8'h3D, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, EV_COMMIT, 47, 4'b0100, 0, 4'b1000, 0);
    run('{8'h26, 8'h3D, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, EV_COMMIT, 37, 4'b0100, 0, 4'b1000, 0);
    run('{8'h45, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, EV_COMMIT, 0, 4'b0001, 0, 4'b0001, 0);
    // Extended prefix skipped: keypad Enter commits 1
    run('{8'h16, 8'hE0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, EV_COMMIT, 1, 4'b0001, 0, 4'b0001, 0);
    // Esc in ENTRY and in ERROR: no event
    run('{8'h16, 8'h76, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, EV_NONE, 0, 4'b0, 0, 4'b0, 0);
    run('{8'h16, 8'h1E, 8'h26, 8'h76, 8'h5A, 8'h00, 8'h00, 8'h00}, 5, EV_NONE, 0, 4'b0, 0, 4'b0, 0);
`ifdef KEYPAD_EN
    run('{8'h69, 8'h72, 8'hE0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}, 4, EV_COMMIT, 12, 4'b0001, 0, 4'b0001, 0);
`else
    run('{8'h69, 8'h72, 8'hE0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}, 4, EV_NONE, 0, 4'b0, 0, 4'b0, 0);
`endif

    // Reset mid-entry discards the partial digit
    run('{8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, EV_NONE, 0, 4'b0, 0, 4'b0, 0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check_zero("midreset");
    reset = 1'b0;
    @(negedge CLK);
    run('{8'h1E, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, EV_COMMIT, 2, 4'b0001, 0, 4'b0001, 0);

    repeat (4) @(negedge CLK);
    check("pending_expectations", q.size(), 0);
    check("event_count", n_events, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
